// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU write port and transmitter launch port of uart_tx_fifo.
// The overflow signal exists only when UART_TX_FIFO_OVF_EN is defined.
// DEPTH must match the DEPTH of the uart_tx_fifo it is attached to.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic          overflow;
`endif

`ifdef UART_TX_FIFO_OVF_EN
  // CPU plus transmitter side
  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, tx_start, tx_data, overflow
  );

  // FIFO side
  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, tx_start, tx_data, overflow
  );
`else
  // CPU plus transmitter side
  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, tx_start, tx_data
  );

  // FIFO side
  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, tx_start, tx_data
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO between the CPU io(0) write port and the
// UART transmitter. A launch FSM pops one byte at a time and pulses tx_start
// whenever the transmitter is idle.
// Optional feature: define UART_TX_FIFO_OVF_EN to get a sticky overflow flag.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic            full_c;
  logic            empty_c;
  logic            wr_ok_c;
  logic            pop_c;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == CW'(0));
  assign wr_ok_c = bus.wr_en && !full_c;

  // Byte storage; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous write and pop leaves count alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_ok_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Launch FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Launch FSM next state; the pop happens during the LAUNCH cycle
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_c && !bus.tx_busy) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        pop_c   = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Start pulse and byte are registered so they are valid for the LAUNCH cycle;
  // tx_data then holds the last launched byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= (state_d == LAUNCH);
      if (state_d == LAUNCH) begin
        tx_data_q <= mem[rd_ptr_q];
      end
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic overflow_q;

  // Sticky flag for any write attempted while full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_en && full_c) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.overflow = overflow_q;
`endif

  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.count    = count_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed, self-checking bench for uart_tx_fifo.
// A per-cycle vector table drives tx_busy directly; the longer sequences use a
// transmitter model that is busy for 10*WAIT cycles starting the cycle after
// tx_start.
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WAIT  = 4;
  localparam int unsigned FRAME = 10 * WAIT;

  logic clk;
  logic reset;
  logic busy_drv;
  logic use_model;
  logic m_busy;
  logic [6:0] m_cnt;
  int cyc;
  int n_cmp;
  int n_err;
  logic [7:0] launch_d[$];
  int         launch_c[$];

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model, reset by the same reset as the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
    end else if (bus.tx_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 7'(FRAME - 1);
    end else if (m_busy) begin
      if (m_cnt == 7'd0) m_busy <= 1'b0;
      else               m_cnt  <= m_cnt - 7'd1;
    end
  end

  assign bus.tx_busy = busy_drv | (use_model & m_busy);

  // Record every launched byte and the cycle it was seen in
  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      launch_d.push_back(bus.tx_data);
      launch_c.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    launch_d.delete();
    launch_c.delete();
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_launches(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (launch_d.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, launch_d.size(), n);
  endtask

  typedef struct packed {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       st;
    logic [7:0] dat;
  } vec_t;

  vec_t vt [18];

  initial begin
    int wcyc;
    reset       = 1'b1;
    busy_drv    = 1'b0;
    use_model   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;

    // Per-cycle vectors: inputs before the edge, outputs after it
    vt[0]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 8'h5A, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h5A};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h5A};
    vt[4]  = '{1'b1, 8'h11, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h5A};
    vt[5]  = '{1'b1, 8'h22, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h5A};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h5A};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 8'h11};
    vt[8]  = '{1'b1, 8'h33, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h11};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h11};
    vt[10] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h11};
    vt[11] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 8'h22};
    vt[12] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[13] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[14] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[15] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h22};
    vt[16] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h33};
    vt[17] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h33};

    // Reset values while reset is held
    @(posedge clk); #1;
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_tx_start", int'(bus.tx_start), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("rst_overflow", int'(bus.overflow), 0);
`endif
    do_reset();
    repeat (20) begin @(posedge clk); #1; end
    chk("idle_no_start", launch_d.size(), 0);

    // Table-driven cycle-exact checks
    do_reset();
    for (int i = 0; i < 18; i++) begin
      bus.wr_en   = vt[i].wr;
      bus.wr_data = vt[i].d;
      busy_drv    = vt[i].busy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), int'(bus.count), int'(vt[i].cnt));
      chk($sformatf("vec%0d_empty", i), int'(bus.empty), int'(vt[i].emp));
      chk($sformatf("vec%0d_full", i), int'(bus.full), int'(vt[i].ful));
      chk($sformatf("vec%0d_tx_start", i), int'(bus.tx_start), int'(vt[i].st));
      chk($sformatf("vec%0d_tx_data", i), int'(bus.tx_data), int'(vt[i].dat));
    end
    bus.wr_en = 1'b0;
    busy_drv  = 1'b0;

    // Three back-to-back bytes through the transmitter model
    use_model = 1'b1;
    do_reset();
    push(8'h41);
    push(8'h42);
    push(8'h43);
    wait_launches(3, 200, "seq3_launches");
    @(posedge clk); #1;
    chk("seq3_empty", int'(bus.empty), 1);
    for (int i = 0; i < 3; i++) begin
      if (i < launch_d.size()) begin
        chk($sformatf("seq3_byte%0d", i), int'(launch_d[i]), 8'h41 + i);
        if (i > 0) chk($sformatf("seq3_gap%0d", i), launch_c[i] - launch_c[i-1], FRAME + 3);
      end
    end

    // Fill past capacity while the transmitter is held busy
    busy_drv = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fill_count16", int'(bus.count), 16);
    chk("fill_full16", int'(bus.full), 1);
`ifdef UART_TX_FIFO_OVF_EN
    chk("fill_ovf_before", int'(bus.overflow), 0);
`endif
    push(8'h10);
    chk("fill_count17", int'(bus.count), 16);
    chk("fill_full17", int'(bus.full), 1);
`ifdef UART_TX_FIFO_OVF_EN
    chk("fill_ovf_after", int'(bus.overflow), 1);
`endif
    busy_drv = 1'b0;
    wait_launches(16, 16 * (FRAME + 3) + 60, "fill_launches");
    repeat (60) begin @(posedge clk); #1; end
    chk("fill_dropped", launch_d.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < launch_d.size()) chk($sformatf("fill_byte%0d", i), int'(launch_d[i]), i);
    end

    // 20-byte stream whose pointers wrap 15 -> 0
    do_reset();
    for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
    repeat (200) begin @(posedge clk); #1; end
    for (int i = 10; i < 20; i++) push(8'hC0 + 8'(i));
    wait_launches(20, 20 * (FRAME + 3) + 100, "wrap_launches");
    for (int i = 0; i < 20; i++) begin
      if (i < launch_d.size()) chk($sformatf("wrap_byte%0d", i), int'(launch_d[i]), 8'hC0 + i);
    end
    @(posedge clk); #1;
    chk("wrap_empty", int'(bus.empty), 1);

    // Reset in WAIT_DONE with three bytes queued, then a normal launch
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
    repeat (10) begin @(posedge clk); #1; end
    chk("midrst_count_before", int'(bus.count), 3);
    do_reset();
    chk("midrst_count", int'(bus.count), 0);
    chk("midrst_empty", int'(bus.empty), 1);
    repeat (20) begin @(posedge clk); #1; end
    chk("midrst_no_start", launch_d.size(), 0);
    push(8'hA5);
    wcyc = cyc;
    wait_launches(1, 10, "midrst_launch");
    if (launch_d.size() > 0) begin
      chk("midrst_byte", int'(launch_d[0]), 8'hA5);
      chk("midrst_latency", launch_c[0], wcyc + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer between the CPU's `io(0)` write port and the UART transmitter on the mother board. CPU writes land in a circular FIFO without stalling. A launch state machine pops one byte at a time into the transmitter, starting it only when the transmitter reports not busy. This lets the CPU issue back-to-back writes instead of polling `busy` between bytes.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; power of two, minimum 2.
- `AW`, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  CPU write strobe, one cycle per byte.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  AW+1  bytes currently stored.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte for the transmitter; valid while `tx_start` is 1.
- `tx_busy`  in  1  transmitter `busy`; rises the cycle after `tx_start` and falls after the stop bit.
- `overflow`  out  1  sticky drop flag; present only under `UART_TX_FIFO_OVF_EN`.

## Operation
- Storage is a DEPTH×8 array with AW-bit `rd_ptr`/`wr_ptr` and a registered `count`. Pointers wrap naturally from DEPTH-1 to 0.
- A write is accepted iff `wr_en && !full`. It stores at `wr_ptr` and increments `wr_ptr`.
- A write while full is dropped. `count`, pointers and contents are unchanged.
- A pop occurs in the LAUNCH state and increments `rd_ptr`.
- Write and pop in the same cycle: both happen and `count` is unchanged.
- `full` and `empty` are combinational from `count`.
- FSM states:
  - IDLE: go to LAUNCH if `!empty && !tx_busy`.
  - LAUNCH: `tx_start=1`, `tx_data=mem[rd_ptr]`, pop; go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when `tx_busy=1`.
  - WAIT_DONE: go to IDLE when `tx_busy=0`.
- `tx_data` holds the last launched byte outside LAUNCH, reset value 0.
- Reset mid-frame clears the FIFO and returns to IDLE. The transmitter is reset by the same `reset`.

## Timing
- Reset values:
  - `full=0`, `empty=1`, `count=0`, `tx_start=0`, `tx_data=8'h00`, `overflow=0`.
  - FSM=IDLE, both pointers 0.
- Write into an empty FIFO while IDLE and `tx_busy=0`:
  - `wr_en` sampled at edge N; `count=1` after N.
  - FSM enters LAUNCH at edge N+1, so `tx_start=1` during cycle N+1→N+2.
  - `count` returns to 0 at edge N+2.
- Back-to-back bytes:
  - The next `tx_start` comes 2 cycles after `tx_busy` falls (WAIT_DONE→IDLE→LAUNCH).
  - Frame period is 10·WAIT + 3 clocks per byte.
- A write is visible to `full` and `count` one cycle after its edge.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined:
  - `overflow` port exists.
  - It is set on the edge where `wr_en && full` and stays set until reset.
- Not defined:
  - The port and its register are absent.
  - Writes to a full FIFO are dropped silently.

## Test plan
- Reset with DEPTH=16:
  - Check `empty=1`, `count=0`, `tx_start=0` and `tx_data=0`.
  - With `tx_busy` held 0, no `tx_start` appears for 20 cycles.
- Single write of `wr_data=8'h5A` at edge N with `tx_busy=0`:
  - `count=1` after N.
  - `tx_start=1` with `tx_data=8'h5A` for exactly one cycle, starting at edge N+1.
  - `count=0` after edge N+2.
- Three consecutive writes `8'h41, 8'h42, 8'h43` with a transmitter model (busy 1 cycle after start, WAIT=4):
  - `tx_start` pulses occur in order 41, 42, 43.
  - Each pulse comes 43 cycles after the previous one.
  - `empty=1` after the third launch.
- Hold `tx_busy=1` and write 17 bytes `8'h00..8'h10`:
  - `full=1` after the 16th write; `count` stays 16.
  - Byte `8'h10` is lost.
  - With `UART_TX_FIFO_OVF_EN`, `overflow=1` after the 17th write.
  - Release `tx_busy`: the transmitter receives bytes 00..0F in order.
- Wrap-around and simultaneous events:
  - Steady-state 20-byte stream crossing `rd_ptr`/`wr_ptr` 15→0 produces the correct sequence.
  - A write on the LAUNCH cycle leaves `count` unchanged.
- Assert `reset` during WAIT_DONE with 3 bytes queued:
  - After release: `count=0`, `empty=1`, no `tx_start`.
  - A new write `8'hA5` launches normally.
